// File: rtl/render_scan_ctrl_if.sv
// Configuration bus for render_scan_ctrl: shadow-register writes, commit request
// and the commit acknowledge pulse.
`ifndef INT_BITS
`define INT_BITS 8
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 16
`endif

interface render_scan_ctrl_if #(
  parameter int IDX_BITS = 3
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [IDX_BITS-1:0]     cfg_idx;
  logic [`INT_BITS-1:0]    cfg_ty;
  logic [`INT_BITS-1:0]    cfg_size;
  logic [`FLOAT_BITS-1:0]  cfg_sin;
  logic [`FLOAT_BITS-1:0]  cfg_cos;
  logic [`FLOAT_BITS-1:0]  cfg_ix;
  logic [`FLOAT_BITS-1:0]  cfg_iy;
  logic                    cfg_commit;
  logic                    commit_done;

  modport master (
    output cfg_valid, cfg_idx, cfg_ty, cfg_size, cfg_sin, cfg_cos, cfg_ix, cfg_iy, cfg_commit,
    input  cfg_ready, commit_done
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_ty, cfg_size, cfg_sin, cfg_cos, cfg_ix, cfg_iy, cfg_commit,
    output cfg_ready, commit_done
  );
endinterface

// File: rtl/render_scan_ctrl.sv
// Raster sequencer for a bank of render_shape instances: h/v counters, frame/line
// strobes, double-buffered shape config swapped in vertical blanking, pixel priority.
`ifndef INT_BITS
`define INT_BITS 8
`endif
`ifndef FLOAT_BITS
`define FLOAT_BITS 16
`endif

module render_scan_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_TOTAL    = 800,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int NUM_SHAPES = 7,
  parameter int IDX_BITS   = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  render_scan_ctrl_if.slave                   cfg,
  output logic                                sh_newframe,
  output logic                                sh_newline,
  output logic [NUM_SHAPES*`INT_BITS-1:0]     sh_ty,
  output logic [NUM_SHAPES*`INT_BITS-1:0]     sh_size,
  output logic [NUM_SHAPES*`FLOAT_BITS-1:0]   sh_sin,
  output logic [NUM_SHAPES*`FLOAT_BITS-1:0]   sh_cos,
  output logic [NUM_SHAPES*`FLOAT_BITS-1:0]   sh_ix,
  output logic [NUM_SHAPES*`FLOAT_BITS-1:0]   sh_iy,
  input  logic [NUM_SHAPES-1:0]               sh_hit,
  output logic                                pix_valid,
  output logic [$clog2(H_TOTAL)-1:0]          pix_x,
  output logic [$clog2(V_TOTAL)-1:0]          pix_y,
  output logic                                pix_hit,
  output logic [IDX_BITS-1:0]                 pix_idx
);
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);

  typedef struct packed {
    logic [`INT_BITS-1:0]   ty;
    logic [`INT_BITS-1:0]   size;
    logic [`FLOAT_BITS-1:0] sin;
    logic [`FLOAT_BITS-1:0] cos;
    logic [`FLOAT_BITS-1:0] ix;
    logic [`FLOAT_BITS-1:0] iy;
  } cfg_t;

  // ty all-ones decodes to "shape off" in render_shape
  localparam cfg_t CFG_RST = cfg_t'({{`INT_BITS{1'b1}}, {(`INT_BITS + 4*`FLOAT_BITS){1'b0}}});

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  logic [XW-1:0]       h_q, h_d;
  logic [YW-1:0]       v_q, v_d;
  logic                h_last, v_last, swap_cycle, pix_active;
  logic                frame_ok_q, frame_ok_d;
  state_t              state_q, state_d;
  logic                cfg_ready, do_swap, wr_en;
  logic                commit_done_q, commit_done_d;
  cfg_t                wr_data;
  logic [IDX_BITS-1:0] hit_idx;
  logic                pix_valid_q, pix_valid_d, pix_hit_q, pix_hit_d;
  logic [XW-1:0]       pix_x_q, pix_x_d;
  logic [YW-1:0]       pix_y_q, pix_y_d;
  logic [IDX_BITS-1:0] pix_idx_q, pix_idx_d;

  assign h_last     = (h_q == XW'(H_TOTAL - 1));
  assign v_last     = (v_q == YW'(V_TOTAL - 1));
  assign swap_cycle = (h_q == '0) && (v_q == YW'(V_ACTIVE));
  assign pix_active = (h_q < XW'(H_ACTIVE)) && (v_q < YW'(V_ACTIVE));

  assign sh_newframe = !rst && h_last && v_last;
  assign sh_newline  = !rst && h_last && (v_q < YW'(V_ACTIVE - 1));

  always_comb begin
    h_d = h_last ? '0 : h_q + XW'(1);
    v_d = v_q;
    if (h_last) v_d = v_last ? '0 : v_q + YW'(1);
    frame_ok_d = frame_ok_q | sh_newframe;
  end

  // Config FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Config FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (cfg.cfg_commit) state_d = ST_PENDING;
      ST_PENDING: if (swap_cycle)     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Config FSM: outputs
  always_comb begin
    cfg_ready     = !rst && (state_q == ST_IDLE);
    do_swap       = (state_q == ST_PENDING) && swap_cycle;
    commit_done_d = do_swap;
  end

  assign cfg.cfg_ready   = cfg_ready;
  assign cfg.commit_done = commit_done_q;

  // Out-of-range indices still complete the handshake; only the store is skipped
  assign wr_en   = cfg.cfg_valid && cfg_ready && (int'(cfg.cfg_idx) < NUM_SHAPES);
  assign wr_data = {cfg.cfg_ty, cfg.cfg_size, cfg.cfg_sin, cfg.cfg_cos, cfg.cfg_ix, cfg.cfg_iy};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SHAPES; gi++) begin : g_shape
      cfg_t shadow_q, shadow_d, active_q, active_d;

      always_comb begin
        shadow_d = shadow_q;
        if (wr_en && (cfg.cfg_idx == IDX_BITS'(gi))) shadow_d = wr_data;
        active_d = do_swap ? shadow_q : active_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q <= CFG_RST;
          active_q <= CFG_RST;
        end else begin
          shadow_q <= shadow_d;
          active_q <= active_d;
        end
      end

      assign sh_ty  [gi*`INT_BITS   +: `INT_BITS]   = active_q.ty;
      assign sh_size[gi*`INT_BITS   +: `INT_BITS]   = active_q.size;
      assign sh_sin [gi*`FLOAT_BITS +: `FLOAT_BITS] = active_q.sin;
      assign sh_cos [gi*`FLOAT_BITS +: `FLOAT_BITS] = active_q.cos;
      assign sh_ix  [gi*`FLOAT_BITS +: `FLOAT_BITS] = active_q.ix;
      assign sh_iy  [gi*`FLOAT_BITS +: `FLOAT_BITS] = active_q.iy;
    end
  endgenerate

  // Lowest set index wins
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
      if (sh_hit[i]) hit_idx = IDX_BITS'(i);
    end
  end

  always_comb begin
    pix_valid_d = pix_active && frame_ok_q;
    pix_hit_d   = pix_valid_d && (|sh_hit);
    pix_idx_d   = pix_valid_d ? hit_idx : '0;
    pix_x_d     = h_q;
    pix_y_d     = v_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      frame_ok_q    <= 1'b0;
      commit_done_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_hit_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_idx_q     <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_ok_q    <= frame_ok_d;
      commit_done_q <= commit_done_d;
      pix_valid_q   <= pix_valid_d;
      pix_hit_q     <= pix_hit_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_idx_q     <= pix_idx_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_hit   = pix_hit_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_idx   = pix_idx_q;
endmodule
